// File: rtl/rv32c_pkg.sv
// Shared RV32C front-end types: data widths, fetch FSM states and the
// {pc, parcel} entry carried through the instruction buffer.
package rv32c_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 16;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'd0;

  typedef enum logic [0:0] {
    FS_FETCH   = 1'b0,
    FS_DISCARD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] parcel;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory req/ack, decode valid/ready and the
// execute-stage redirect. The master view belongs to the sequencer.
interface fetch_sequencer_if;
  import rv32c_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_data;
  logic            inst_valid;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_data, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_data, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/inst_fifo.sv
// Synchronous instruction buffer of {pc, parcel} entries. Flush beats push and
// pop; the head entry is read straight from storage so outputs are registered.
module inst_fifo
  import rv32c_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// RV32C fetch sequencer: owns the fetch PC, issues 16-bit fetches with a
// registered req/addr, buffers parcels for decode and applies redirects.
module fetch_sequencer
  import rv32c_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input logic              clock,
  input logic              reset,
  fetch_sequencer_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_e    state;
  fetch_state_e    state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_n;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] addr_n;
  logic            req;
  logic            req_n;

  logic            accept;
  logic            push;
  logic            pop;
  logic            room;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  fetch_entry_t    entry;
  fetch_entry_t    head;

  // Only right-path acks reach the buffer; a redirect voids push and pop.
  assign accept = req && bus.imem_ack;
  assign push   = accept && (state == FS_FETCH) && !bus.redirect;
  assign pop    = !empty && bus.inst_ready && !bus.redirect;
  assign entry  = '{pc: addr, parcel: bus.imem_data};

  inst_fifo #(.DEPTH(DEPTH)) u_inst_fifo (
    .clock (clock),
    .reset (reset),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr;
  assign bus.inst_valid = !empty;
  assign bus.inst       = head.parcel;
  assign bus.inst_pc    = head.pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FS_FETCH;
      fetch_pc <= RESET_PC;
      req      <= 1'b0;
      addr     <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req      <= req_n;
      addr     <= addr_n;
    end
  end

  // Next state; req for the next cycle depends on occupancy after this cycle.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_n      = req;
    addr_n     = addr;
    room       = (push == pop) ? !full
               : (push ? (count != CW'(DEPTH - 1)) : 1'b1);

    if (bus.redirect) begin
      fetch_pc_n = bus.redirect_pc & ~XLEN'(1);
      if (req && !bus.imem_ack) begin
        state_n = FS_DISCARD;
        req_n   = 1'b1;
      end else begin
        state_n = FS_FETCH;
        req_n   = 1'b1;
        addr_n  = fetch_pc_n;
      end
    end else begin
      unique case (state)
        FS_FETCH: begin
          if (accept) begin
            fetch_pc_n = fetch_pc + XLEN'(2);
          end
          if (!req || accept) begin
            req_n  = room;
            addr_n = fetch_pc_n;
          end
        end
        FS_DISCARD: begin
          if (bus.imem_ack) begin
            state_n = FS_FETCH;
            req_n   = room;
            addr_n  = fetch_pc;
          end
        end
        default: state_n = FS_FETCH;
      endcase
    end
  end

endmodule
